mdu: RTL and testbench

Iterative multiply/divide unit for the pipelined MIPS core, sitting in the EX stage beside the ALU. It accepts operands from the ID/EX forwarding muxes and owns the architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. While a multiply or divide is running it raises `busy`, and hazard control uses that signal to stall any following MDU instruction or MFHI/MFLO.

---
 rtl/mdu.sv | 132 +++++++++++++
 tb/tb_mdu.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Owns the architectural HI/LO registers; fixed 33-cycle latency per MULT/DIV.
module mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic [WIDTH-1:0]   a_orig;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;

  logic               op_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state != IDLE);

  always_comb begin
    op_signed = ~op[0];
    mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;
    // Multiplier bits are consumed LSB first; the product shifts right into acc.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mb[0] ? {1'b0, ma} : '0);
    // Trial subtract of the shifted partial remainder; sign bit gives the quotient bit.
    diff      = {rem, ma[WIDTH-1]} - {2'b0, mb};
    q_bit     = ~diff[WIDTH+1];
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ma     <= '0;
      mb     <= '0;
      a_orig <= '0;
      acc    <= '0;
      rem    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              state  <= CALC;
              cnt    <= '0;
              acc    <= '0;
              rem    <= '0;
              ma     <= mag_a;
              mb     <= mag_b;
              a_orig <= a;
              is_div <= op[1];
              neg_q  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r  <= op_signed & a[WIDTH-1];
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        CALC: begin
          if (is_div) begin
            rem              <= q_bit ? diff[WIDTH:0] : {rem[WIDTH-1:0], ma[WIDTH-1]};
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], q_bit};
            ma               <= ma << 1;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            mb  <= mb >> 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            if (mb == '0) begin
              lo <= '1;
              hi <= a_orig;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected {hi,lo} and completion cycle are queued at issue
// and checked by a monitor on every done pulse; MTHI/MTLO are checked inline.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like MIPS.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p, q, r;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = longint'(x);
    uy = longint'(y);
    case (o)
      3'd0: begin p = sx * sy; return p; end
      3'd1: begin p = ux * uy; return p; end
      3'd2, 3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (o == 3'd2) begin q = sx / sy; r = sx % sy; end
        else begin q = ux / uy; r = ux % uy; end
        return {r[31:0], q[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  int unsigned run = 0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      chk("busy_len", 64'(run), 64'd33);
      run = 0;
      if (sbq.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_hilo"}, {hi, lo}, e.res);
        chk({e.name, "_lat"}, 64'(cyc), 64'(e.due));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end else if (busy) begin
      run++;
    end else begin
      run = 0;
    end
  end

  task automatic wait_idle();
    int unsigned w = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string nm);
    wait_idle();
    start = 1'b1; op = o; a = x; b = y;
    if (!o[2]) sbq.push_back('{model(o, x, y), cyc + 34, nm});
    @(posedge clk);
    #1;
    start = 1'b0;
    if (o == 3'd4) chk({nm, "_hi"}, 64'(hi), 64'(x));
    if (o == 3'd5) chk({nm, "_lo"}, 64'(lo), 64'(x));
    if (o[2]) chk({nm, "_busydone"}, {62'd0, busy, done}, 64'd0);
    else chk({nm, "_busy"}, 64'(busy), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {30'd0, busy, done, hi, lo} , 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    issue(3'd0, 32'hFFFFFFFD, 32'd7,        "mult_neg");
    issue(3'd0, 32'h80000000, 32'h80000000, "mult_min");
    issue(3'd2, 32'hFFFFFFF9, 32'd2,        "div_neg");
    issue(3'd3, 32'd7,        32'd2,        "divu_small");
    issue(3'd3, 32'hFFFFFFF9, 32'd2,        "divu_big");
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");

    issue(3'd4, 32'hDEADBEEF, 32'd0, "mthi");
    issue(3'd5, 32'h0BADF00D, 32'd0, "mtlo");
    issue(3'd1, 32'd2, 32'd3, "multu_ign");
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h11111111;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign_hold_hi", 64'(hi), 64'hDEADBEEF);
    chk("ign_hold_lo", 64'(lo), 64'h0BADF00D);

    issue(3'd2, 32'h12345678, 32'd0, "div_zero");
    issue(3'd3, 32'd100, 32'd7, "divu_rst");
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", {30'd0, busy, done, hi, lo}, 64'd0);
    void'(sbq.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b1;
    issue(3'd3, 32'd100, 32'd7, "divu_after");

    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 5));
      issue(o, pick(), pick(), "rand");
    end

    wait_idle();
    repeat (3) @(negedge clk);
    if (sbq.size() != 0) chk("drain", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
